// File: rtl/forwarder_pkg.sv
// Shared constants for the N-port frame forwarder: word format, arbiter states, counter width.
package forwarder_pkg;

    localparam int unsigned FWD_DW      = 9;
    localparam int unsigned FWD_EOF_BIT = FWD_DW - 1;
    localparam int unsigned DROP_CNT_W  = 16;

    localparam logic ARB_IDLE   = 1'b0;
    localparam logic ARB_LOCKED = 1'b1;

endpackage

// File: rtl/forwarder_nport_if.sv
// FIFO-side bundle of the forwarder: rx FIFO heads/pops and tx FIFO writes for all ports.
interface forwarder_nport_if
    import forwarder_pkg::*;
#(
    parameter int unsigned NPORTS = 4,
    parameter int unsigned DW     = FWD_DW
);

    logic [NPORTS*DW-1:0] rx_dout;
    logic [NPORTS-1:0]    rx_empty;
    logic [NPORTS-1:0]    rx_rd_en;
    logic [NPORTS*DW-1:0] tx_din;
    logic [NPORTS-1:0]    tx_full;
    logic [NPORTS-1:0]    tx_wr_en;

    modport master (
        input  rx_dout, rx_empty, tx_full,
        output rx_rd_en, tx_din, tx_wr_en
    );

    modport slave (
        output rx_dout, rx_empty, tx_full,
        input  rx_rd_en, tx_din, tx_wr_en
    );

endinterface

// File: rtl/fwd_tx_arbiter.sv
// Frame-granular round-robin arbiter for one tx port; owns the registered tx write path.
module fwd_tx_arbiter
    import forwarder_pkg::*;
#(
    parameter int unsigned NPORTS = 4,
    parameter int unsigned PW     = 2,
    parameter int unsigned DW     = FWD_DW
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NPORTS-1:0]    req_i,
    input  logic [NPORTS*DW-1:0] rx_dout_i,
    input  logic [NPORTS-1:0]    rx_empty_i,
    input  logic                 tx_full_i,
    output logic [NPORTS-1:0]    rd_en_o,
    output logic [DW-1:0]        tx_din_o,
    output logic                 tx_wr_en_o
);

    logic          state_q, state_d;
    logic [PW-1:0] grant_q, grant_d;
    logic [PW-1:0] rr_ptr_q, rr_ptr_d;
    logic [DW-1:0] tx_din_q, tx_din_d;
    logic          tx_wr_en_q, tx_wr_en_d;
    logic [DW-1:0] head;
    logic          pop;
    logic          found;
    int unsigned   idx;

    assign head = rx_dout_i[grant_q*DW +: DW];
    assign pop  = (state_q == ARB_LOCKED) && !rx_empty_i[grant_q] && !tx_full_i;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        tx_din_d   = tx_din_q;
        tx_wr_en_d = pop;
        rd_en_o    = '0;
        found      = 1'b0;
        idx        = 0;
        if (state_q == ARB_IDLE) begin
            // First requester at or after rr_ptr, wrapping modulo NPORTS.
            for (int unsigned k = 0; k < NPORTS; k++) begin
                idx = (32'(rr_ptr_q) + k) % NPORTS;
                if (!found && req_i[idx]) begin
                    found   = 1'b1;
                    grant_d = PW'(idx);
                    state_d = ARB_LOCKED;
                end
            end
        end else begin
            rd_en_o[grant_q] = pop;
            if (pop) begin
                tx_din_d = head;
                if (!head[DW-1]) begin
                    state_d  = ARB_IDLE;
                    rr_ptr_d = (grant_q == PW'(NPORTS - 1)) ? '0 : grant_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ARB_IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            tx_din_q   <= '0;
            tx_wr_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            tx_din_q   <= tx_din_d;
            tx_wr_en_q <= tx_wr_en_d;
        end
    end

    assign tx_din_o   = tx_din_q;
    assign tx_wr_en_o = tx_wr_en_q;

endmodule

// File: rtl/forwarder_nport.sv
// N-port frame forwarder: per-rx destination latch and drop drain, one arbiter per tx port.
module forwarder_nport
    import forwarder_pkg::*;
#(
    parameter int unsigned NPORTS = 4,
    parameter int unsigned PW     = $clog2(NPORTS),
    parameter int unsigned DW     = FWD_DW
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    forwarder_nport_if.master      bus,
    input  logic [NPORTS*PW-1:0]   dest_map,
    input  logic [NPORTS-1:0]      port_en,
    output logic [DROP_CNT_W-1:0]  drop_cnt
);

    logic [NPORTS-1:0]     active_q, active_d;
    logic [NPORTS-1:0]     fwd_q, fwd_d;
    logic [PW-1:0]         dst_q [NPORTS];
    logic [PW-1:0]         dst_d [NPORTS];
    logic [PW-1:0]         new_dst [NPORTS];
    logic [PW-1:0]         eff_dst [NPORTS];
    logic [NPORTS-1:0]     new_fwd, eff_fwd, drain_rd, rx_eof, rd_en;
    logic [NPORTS-1:0]     req [NPORTS];
    logic [NPORTS-1:0]     arb_rd [NPORTS];
    logic [DW-1:0]         tx_din_arr [NPORTS];
    logic [NPORTS-1:0]     tx_wr_arr;
    logic [NPORTS*DW-1:0]  tx_din_pk;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [DROP_CNT_W:0]   n_drop, drop_sum;

    // Outside a frame the live dest_map applies; it is captured for the rest of the frame.
    always_comb begin
        for (int i = 0; i < NPORTS; i++) begin
            new_dst[i]  = dest_map[i*PW +: PW];
            new_fwd[i]  = (32'(new_dst[i]) < NPORTS) && port_en[new_dst[i]];
            eff_dst[i]  = active_q[i] ? dst_q[i] : new_dst[i];
            eff_fwd[i]  = active_q[i] ? fwd_q[i] : new_fwd[i];
            rx_eof[i]   = !bus.rx_dout[i*DW + DW - 1];
            drain_rd[i] = !sys_rst && !eff_fwd[i] && !bus.rx_empty[i];
        end
    end

    always_comb begin
        for (int j = 0; j < NPORTS; j++) begin
            for (int i = 0; i < NPORTS; i++) begin
                req[j][i] = eff_fwd[i] && (active_q[i] || !bus.rx_empty[i])
                            && (eff_dst[i] == PW'(j));
            end
        end
    end

    always_comb begin
        rd_en = drain_rd;
        for (int j = 0; j < NPORTS; j++) begin
            rd_en = rd_en | arb_rd[j];
        end
    end

    assign bus.rx_rd_en = rd_en;

    // Several rx may finish a dropped frame in the same cycle.
    always_comb begin
        n_drop = '0;
        for (int i = 0; i < NPORTS; i++) begin
            active_d[i] = (active_q[i] || !bus.rx_empty[i]) && !(rd_en[i] && rx_eof[i]);
            dst_d[i]    = eff_dst[i];
            fwd_d[i]    = eff_fwd[i];
            if (drain_rd[i] && rx_eof[i]) begin
                n_drop = n_drop + 1'b1;
            end
        end
        drop_sum   = {1'b0, drop_cnt_q} + n_drop;
        drop_cnt_d = drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            active_q   <= '0;
            fwd_q      <= '0;
            drop_cnt_q <= '0;
            for (int i = 0; i < NPORTS; i++) begin
                dst_q[i] <= '0;
            end
        end else begin
            active_q   <= active_d;
            fwd_q      <= fwd_d;
            drop_cnt_q <= drop_cnt_d;
            for (int i = 0; i < NPORTS; i++) begin
                dst_q[i] <= dst_d[i];
            end
        end
    end

    for (genvar j = 0; j < NPORTS; j++) begin : g_arb
        fwd_tx_arbiter #(
            .NPORTS (NPORTS),
            .PW     (PW),
            .DW     (DW)
        ) u_arb (
            .clk_i      (sys_clk),
            .rst_i      (sys_rst),
            .req_i      (req[j]),
            .rx_dout_i  (bus.rx_dout),
            .rx_empty_i (bus.rx_empty),
            .tx_full_i  (bus.tx_full[j]),
            .rd_en_o    (arb_rd[j]),
            .tx_din_o   (tx_din_arr[j]),
            .tx_wr_en_o (tx_wr_arr[j])
        );
    end

    always_comb begin
        tx_din_pk = '0;
        for (int j = 0; j < NPORTS; j++) begin
            tx_din_pk[j*DW +: DW] = tx_din_arr[j];
        end
    end

    assign bus.tx_din   = tx_din_pk;
    assign bus.tx_wr_en = tx_wr_arr;
    assign drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_forwarder_nport.sv
// Bench for forwarder_nport: FIFO models around the DUT, frames tagged with their source rx.
module tb_forwarder_nport;
    import forwarder_pkg::*;

    localparam int unsigned NP  = 4;
    localparam int unsigned PW  = 2;
    localparam int unsigned DW  = FWD_DW;
    localparam int          CAP = 4;

    logic           sys_clk = 1'b0;
    logic           sys_rst = 1'b1;
    logic [NP*PW-1:0] dest_map;
    logic [NP-1:0]  port_en;
    logic [15:0]    drop_cnt;

    forwarder_nport_if #(.NPORTS(NP), .DW(DW)) bus ();

    forwarder_nport #(.NPORTS(NP), .PW(PW), .DW(DW)) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .bus      (bus),
        .dest_map (dest_map),
        .port_en  (port_en),
        .drop_cnt (drop_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    // Reference state: rx FIFO contents, per-source expected words and destinations.
    logic [DW-1:0] rxq  [NP][$];
    logic [DW-1:0] expw [NP][$];
    int            expd [NP][$];
    int            order0 [$];
    int tx_cnt [NP];
    int cur_src [NP];
    int wr_count [NP];
    int first_rd [NP];
    int first_wr [NP];
    int last_wr [NP];
    int drops_exp;
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int gap_pct = 0;
    int drain_pct = 100;
    int bad_pop = 0;
    int overflow = 0;
    logic [NP-1:0] full_toggle = '0;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_dest(input int rx, input int d);
        dest_map[rx*PW +: PW] = PW'(d);
    endtask

    task automatic push_frame(input int src, input int len, input int dst, input bit fwd);
        logic [DW-1:0] w;
        for (int k = 0; k < len; k++) begin
            w = {(k != len - 1), 2'(src), 6'($urandom_range(0, 63))};
            rxq[src].push_back(w);
            if (fwd) expw[src].push_back(w);
        end
        if (fwd) expd[src].push_back(dst);
        else drops_exp++;
    endtask

    task automatic take_word(input int j, input logic [DW-1:0] w);
        int s;
        if (cur_src[j] < 0) begin
            s = int'(w[7:6]);
            cur_src[j] = s;
            if (j == 0) order0.push_back(s);
            if (expd[s].size() == 0) check("unexpected_frame", 1, 0);
            else check("frame_dest", j, expd[s].pop_front());
        end
        s = cur_src[j];
        if (expw[s].size() == 0) check("extra_word", 1, 0);
        else check("tx_word", w, expw[s].pop_front());
        if (!w[DW-1]) cur_src[j] = -1;
    endtask

    task automatic sample();
        for (int i = 0; i < NP; i++) begin
            if (bus.rx_rd_en[i]) begin
                if (bus.rx_empty[i]) bad_pop++;
                else begin
                    void'(rxq[i].pop_front());
                    if (first_rd[i] < 0) first_rd[i] = cyc;
                end
            end
        end
        for (int j = 0; j < NP; j++) begin
            if (bus.tx_wr_en[j]) begin
                if (tx_cnt[j] >= CAP) overflow++;
                tx_cnt[j]++;
                wr_count[j]++;
                if (first_wr[j] < 0) first_wr[j] = cyc;
                last_wr[j] = cyc;
                take_word(j, bus.tx_din[j*DW +: DW]);
            end
            if (tx_cnt[j] > 0 && int'($urandom_range(0, 99)) < drain_pct) tx_cnt[j]--;
        end
    endtask

    // One clock: drive at negedge, sample 1 ns before posedge, return just after posedge.
    task automatic step();
        @(negedge sys_clk);
        for (int i = 0; i < NP; i++) begin
            if (rxq[i].size() == 0 || int'($urandom_range(0, 99)) < gap_pct) begin
                bus.rx_empty[i] = 1'b1;
                bus.rx_dout[i*DW +: DW] = '0;
            end else begin
                bus.rx_empty[i] = 1'b0;
                bus.rx_dout[i*DW +: DW] = rxq[i][0];
            end
            bus.tx_full[i] = (CAP - tx_cnt[i] <= 1) || (full_toggle[i] && ((cyc / 3) % 2 == 1));
        end
        #4;
        sample();
        cyc++;
        @(posedge sys_clk);
        #1;
    endtask

    function automatic bit rx_pending();
        for (int i = 0; i < NP; i++) if (rxq[i].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic run_until_idle(input int budget);
        int n = 0;
        while (rx_pending() && n < budget) begin
            step();
            n++;
        end
        if (rx_pending()) check("idle_timeout", 1, 0);
        repeat (4) step();
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst = 1'b1;
        #1;
        check("rst_rd_en", bus.rx_rd_en, 0);
        check("rst_wr_en", bus.tx_wr_en, 0);
        check("rst_tx_din", bus.tx_din, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        for (int i = 0; i < NP; i++) begin
            rxq[i].delete();
            expw[i].delete();
            expd[i].delete();
            tx_cnt[i] = 0;
            cur_src[i] = -1;
            wr_count[i] = 0;
            first_rd[i] = -1;
            first_wr[i] = -1;
            last_wr[i] = -1;
        end
        order0.delete();
        drops_exp = 0;
        gap_pct = 0;
        drain_pct = 100;
        full_toggle = '0;
        bus.rx_empty = '1;
        bus.rx_dout = '0;
        @(negedge sys_clk);
        sys_rst = 1'b0;
    endtask

    initial begin
        int d;
        bus.rx_empty = '1;
        bus.rx_dout  = '0;
        bus.tx_full  = '0;
        dest_map     = '0;
        port_en      = '1;

        // 65-word frame rx0 -> tx1: latency and gapless streaming.
        dest_map = {2'd0, 2'd3, 2'd2, 2'd1};
        do_reset();
        push_frame(0, 65, 1, 1'b1);
        run_until_idle(500);
        check("t1_words", wr_count[1], 65);
        check("t1_latency", first_wr[1] - first_rd[0], 1);
        check("t1_gapless", last_wr[1] - first_wr[1], 64);
        check("t1_left", expw[0].size(), 0);

        // rx1 and rx2 contend for tx0: frames alternate.
        dest_map = {2'd3, 2'd0, 2'd0, 2'd1};
        do_reset();
        for (int f = 0; f < 3; f++) begin
            push_frame(1, int'($urandom_range(1, 6)), 0, 1'b1);
            push_frame(2, int'($urandom_range(1, 6)), 0, 1'b1);
        end
        run_until_idle(500);
        check("t2_frames", order0.size(), 6);
        for (int k = 0; k < order0.size(); k++) check("t2_order", order0[k], (k % 2 == 0) ? 1 : 2);

        // tx_full[1] toggling every 3 cycles.
        dest_map = {2'd0, 2'd3, 2'd2, 2'd1};
        do_reset();
        full_toggle[1] = 1'b1;
        push_frame(0, 20, 1, 1'b1);
        push_frame(0, 20, 1, 1'b1);
        run_until_idle(1000);
        check("t3_words", wr_count[1], 40);
        check("t3_left", expw[0].size(), 0);

        // Disabled tx2: drain and count, then saturate.
        port_en = 4'b1011;
        do_reset();
        for (int f = 0; f < 5; f++) push_frame(1, int'($urandom_range(1, 6)), 2, 1'b0);
        run_until_idle(500);
        check("t4_drop5", drop_cnt, 5);
        check("t4_no_wr", wr_count[2], 0);
        port_en = '0;
        for (int k = 0; k < 16383; k++) begin
            push_frame(0, 1, 0, 1'b0);
            push_frame(1, 1, 0, 1'b0);
            if (k < 16382) begin
                push_frame(2, 1, 0, 1'b0);
                push_frame(3, 1, 0, 1'b0);
            end
        end
        run_until_idle(20000);
        check("t4_drops_total", drops_exp, 65535);
        check("t4_sat", drop_cnt, 16'hFFFF);
        push_frame(2, 3, 0, 1'b0);
        run_until_idle(100);
        check("t4_sat_hold", drop_cnt, 16'hFFFF);
        check("t4_no_wr_all", wr_count[0] + wr_count[1] + wr_count[2] + wr_count[3], 0);
        port_en = '1;

        // dest_map[0] 1 -> 2 mid-frame.
        dest_map = {2'd0, 2'd3, 2'd2, 2'd1};
        do_reset();
        push_frame(0, 12, 1, 1'b1);
        push_frame(0, 6, 2, 1'b1);
        for (int n = 0; n < 20 && first_rd[0] < 0; n++) step();
        check("t5_started", first_rd[0] >= 0, 1);
        repeat (3) step();
        set_dest(0, 2);
        run_until_idle(500);
        check("t5_tx1", wr_count[1], 12);
        check("t5_tx2", wr_count[2], 6);

        // Reset in the middle of a frame, then a clean frame.
        dest_map = {2'd0, 2'd3, 2'd2, 2'd1};
        do_reset();
        push_frame(0, 20, 1, 1'b1);
        for (int n = 0; n < 20 && first_rd[0] < 0; n++) step();
        repeat (5) step();
        do_reset();
        push_frame(0, 8, 1, 1'b1);
        run_until_idle(500);
        check("t6_words", wr_count[1], 8);
        check("t6_left", expw[0].size(), 0);

        // Random rounds: random map/enables, rx gaps and tx back-pressure.
        for (int r = 0; r < 3; r++) begin
            dest_map = NP*PW'($urandom);
            port_en  = NP'($urandom);
            do_reset();
            gap_pct   = 20;
            drain_pct = 50;
            for (int i = 0; i < NP; i++) begin
                d = int'(dest_map[i*PW +: PW]);
                repeat ($urandom_range(1, 4))
                    push_frame(i, int'($urandom_range(1, 8)), d, port_en[d]);
            end
            run_until_idle(3000);
            check("rand_drop_cnt", drop_cnt, drops_exp);
            for (int i = 0; i < NP; i++) check("rand_left", expw[i].size(), 0);
        end

        check("bad_pop", bad_pop, 0);
        check("tx_overflow", overflow, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/forwarder_nport.md
# forwarder_nport

Parametrised N-port frame forwarder, successor to the fixed two-port cross-connect between MAC rx and tx FIFOs. Each rx FIFO has a runtime-selectable destination tx port. Each tx port runs a frame-granular round-robin arbiter, so frames from different sources never interleave. It honours tx back-pressure and discards frames aimed at disabled ports.

## Interface
Parameters:
- NPORTS, 4, number of rx/tx port pairs (2..16)
- PW, $clog2(NPORTS), width of one destination index
- DW, 9, FIFO word width; bit DW-1 = in-frame flag (1 = frame data, 0 = end-of-frame word)

Ports:
- sys_clk  in  1  clock
- sys_rst  in  1  reset, asynchronous, active-high
- rx_dout  in  NPORTS*DW  rx FIFO heads, port i at [i*DW +: DW]; first-word-fall-through, valid when rx_empty[i]=0
- rx_empty  in  NPORTS  rx FIFO empty flags
- rx_rd_en  out  NPORTS  pop strobes (combinational)
- tx_din  out  NPORTS*DW  tx FIFO write data, registered
- tx_full  in  NPORTS  tx FIFO full; asserted when ≤1 entry free
- tx_wr_en  out  NPORTS  tx write strobes, registered
- dest_map  in  NPORTS*PW  destination tx index for rx i at [i*PW +: PW]
- port_en  in  NPORTS  tx port enable mask
- drop_cnt  out  16  frames discarded, saturating at 16'hFFFF

## Operation
- Frame = contiguous words from one rx; terminated by the first word with bit DW-1 = 0, which is forwarded. A lone bit-8=0 word is a one-word frame.
- Per rx i, at frame start: dest d = dest_map[i], ignored if d ≥ NPORTS (treated as disabled). d and port_en[d] are latched for the whole frame. Later changes affect only the next frame.
- Forward path: rx i raises a request to arbiter d.
- Drop path (port_en[d]=0 or d out of range): rx i drains on its own. rx_rd_en[i] = !rx_empty[i] until the end word is popped. drop_cnt increments once per frame, on its end word.
- Arbiter per tx j, states:
  - IDLE: choose the lowest requesting index at or after rr_ptr (modulo NPORTS); register grant → LOCKED.
  - LOCKED: rx_rd_en[g] = !rx_empty[g] && !tx_full[j]. After the end word is popped → IDLE, and rr_ptr = g+1 mod NPORTS.
- Each rx is owned by at most one arbiter or the drain path at any time.
- A disabled tx already in LOCKED finishes its current frame.

## Timing
- Reset (async assert, sync release): rx_rd_en=0, tx_wr_en=0, tx_din=0, drop_cnt=0, all arbiters IDLE, rr_ptr=0, no rx latched.
- Pop of rx word at cycle t → tx_wr_en=1 with that word on tx_din at t+1.
- Throughput while LOCKED: one word/cycle; tx_full slack covers the one in-flight write.
- Frame turnaround: end word popped at t; arbiter in IDLE at t+1; next frame's first pop at t+2 at earliest.
- rx_empty mid-frame: pop stalls, lock held, no timeout.
- tx_full mid-frame: no pop that cycle; the in-flight word is still written.
- Two rx requesting the same idle tx: the winner is the one at or after rr_ptr; the loser waits, no data loss.
- Reset mid-frame: a partial frame left in a tx FIFO is not cleaned up; downstream MAC discards it.

## Structure
- Package forwarder_pkg: DW, EOF bit index (DW-1), arbiter state enum {IDLE, LOCKED}, drop counter width.
- Sub-module fwd_tx_arbiter: one per tx port via generate. Holds state, grant, rr_ptr and the registered tx_din/tx_wr_en.
- Top level holds the per-rx destination latch and drain logic, the request matrix, rd_en OR-reduction and drop_cnt.

## Test plan
- NPORTS=4, dest_map={0,3,2,1} (rx3→0, rx2→3, rx1→2, rx0→1): 64-byte frame into rx0 → exactly those 65 words on tx1, first tx_wr_en one cycle after first rx_rd_en, no gaps.
- rx1 and rx2 both →tx0, 3 frames each, simultaneous: tx0 receives frames alternating rx1,rx2,…, no word interleaving.
- tx_full[1] toggled every 3 cycles during a frame: no word lost or duplicated, and no tx_wr_en while the tx FIFO has 0 free entries.
- port_en[2]=0 with 5 frames to tx2: rx drained, tx_wr_en[2] never asserted, drop_cnt=5. Force count to FFFF and drop once more → stays FFFF.
- dest_map[0] changed from 1 to 2 mid-frame: the rest of the frame goes to tx1, the next frame to tx2.
- sys_rst asserted mid-frame for 1 cycle: all outputs 0 immediately, arbiters IDLE. After release, the next frame is forwarded normally.
